// File: rtl/tff_lockstep_checker.sv
// Lockstep checker for the three-way T flip-flop stage (SR-, JK- and D-based).
// Runs a golden TFF alongside the stage, flags which implementation diverges,
// and exposes a majority-voted Q plus mismatch/toggle counters.
module tff_lockstep_checker #(
  parameter int CNT_W        = 8,
  parameter int GUARD_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             t_in_i,
  input  logic             q_sr_i,
  input  logic             q_jk_i,
  input  logic             q_d_i,
  input  logic             clr_err_i,
  output logic             q_ref_o,
  output logic             q_vote_o,
  output logic             mismatch_o,
  output logic [2:0]       err_mask_o,
  output logic [CNT_W-1:0] mismatch_cnt_o,
  output logic [CNT_W-1:0] toggle_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_GUARD  = 2'd0,
    S_CHECK  = 2'd1,
    S_FAULT  = 2'd2,
    S_UNUSED = 2'd3
  } state_e;

  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);

  state_e           state_q;
  logic [3:0]       guard_q;
  logic             q_ref_q;
  logic             mismatch_q;
  logic [2:0]       err_mask_q;
  logic [CNT_W-1:0] mismatch_cnt_q;
  logic [CNT_W-1:0] toggle_cnt_q;

  logic             q_vote;
  logic [2:0]       diff;
  logic [CNT_W-1:0] toggle_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_d;

  // Majority vote, per-implementation disagreement and counter next values.
  always_comb begin
    q_vote         = (q_sr_i & q_jk_i) | (q_sr_i & q_d_i) | (q_jk_i & q_d_i);
    diff           = {q_d_i ^ q_ref_q, q_jk_i ^ q_ref_q, q_sr_i ^ q_ref_q};
    toggle_cnt_d   = toggle_cnt_q + {{(CNT_W-1){1'b0}}, t_in_i};
    // Saturate rather than wrap so a long-running fault never reads as clean.
    mismatch_cnt_d = (&mismatch_cnt_q) ? mismatch_cnt_q : mismatch_cnt_q + 1'b1;
  end

  // Golden model, guard/check/fault FSM and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_GUARD;
      guard_q        <= GUARD_INIT;
      q_ref_q        <= 1'b0;
      mismatch_q     <= 1'b0;
      err_mask_q     <= 3'b000;
      mismatch_cnt_q <= '0;
      toggle_cnt_q   <= '0;
    end else begin
      toggle_cnt_q <= toggle_cnt_d;
      mismatch_q   <= 1'b0;
      if (clr_err_i) begin
        // Resync to the majority so one bad implementation cannot steer the model.
        q_ref_q        <= q_vote ^ t_in_i;
        err_mask_q     <= 3'b000;
        mismatch_cnt_q <= '0;
        state_q        <= S_GUARD;
        guard_q        <= GUARD_INIT;
      end else begin
        q_ref_q <= q_ref_q ^ t_in_i;
        case (state_q)
          S_GUARD: begin
            // The edge that drains the counter is itself discarded.
            if (guard_q <= 4'd1) begin
              guard_q <= 4'd0;
              state_q <= S_CHECK;
            end else begin
              guard_q <= guard_q - 4'd1;
            end
          end
          S_CHECK, S_FAULT: begin
            if (|diff) begin
              mismatch_q     <= 1'b1;
              err_mask_q     <= err_mask_q | diff;
              mismatch_cnt_q <= mismatch_cnt_d;
              state_q        <= S_FAULT;
            end
          end
          default: begin
            state_q <= S_GUARD;
            guard_q <= GUARD_INIT;
          end
        endcase
      end
    end
  end

  assign q_ref_o        = q_ref_q;
  assign q_vote_o       = q_vote;
  assign mismatch_o     = mismatch_q;
  assign err_mask_o     = err_mask_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign toggle_cnt_o   = toggle_cnt_q;
  assign state_o        = state_q;

endmodule
